// File: rtl/move_input_if.sv
// Button inputs and move outputs shared between the board front-end and gameController.
// The slave side is the move_input block itself.
interface move_input_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_reset;
  logic [2:0] dir;
  logic       game_rst;
  logic       busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_reset,
    input  dir, game_rst, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_reset,
    output dir, game_rst, busy
  );
endinterface

// File: rtl/move_input.sv
// 2048 input stage: synchronize and debounce five buttons, turn presses into
// single-cycle move codes gated by a lockout window with a one-deep pending slot.
module move_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LOCKOUT_CYCLES  = 48
) (
  input  logic        clk,
  input  logic        rst,
  move_input_if.slave io
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [2:0]    DIR_IDLE  = 3'd4;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 new-game.
  logic [4:0] btn_raw;
  logic [4:0] s1_q, s1_d;
  logic [4:0] s2_q, s2_d;
  logic [4:0] deb_q, deb_d;
  logic [4:0] deb_dly_q, deb_dly_d;
  logic [DW-1:0] deb_cnt_q [5];
  logic [DW-1:0] deb_cnt_d [5];
  logic [LW-1:0] lock_q, lock_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    dir_q, dir_d;
  logic          game_rst_q, game_rst_d;

  logic [4:0] press;
  logic       win_valid;
  logic [1:0] win_code;

  assign btn_raw = {io.btn_reset, io.btn_right, io.btn_left, io.btn_down, io.btn_up};

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = s2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    win_valid = 1'b1;
    win_code  = 2'd0;
    if (press[0])      win_code = 2'd0;
    else if (press[1]) win_code = 2'd1;
    else if (press[2]) win_code = 2'd2;
    else if (press[3]) win_code = 2'd3;
    else               win_valid = 1'b0;
  end

  // New-game press wins over everything; a fresh move beats a stale pending one.
  always_comb begin
    dir_d      = DIR_IDLE;
    game_rst_d = 1'b0;
    pend_d     = pend_q;
    lock_d     = (lock_q == '0) ? '0 : lock_q - 1'b1;
    if (press[4]) begin
      game_rst_d = 1'b1;
      lock_d     = '0;
      pend_d     = '0;
    end else if (win_valid) begin
      if (lock_q == '0) begin
        dir_d  = {1'b0, win_code};
        lock_d = LOCK_LOAD;
        pend_d = '0;
      end else begin
        pend_d = {1'b1, win_code};
      end
    end else if ((lock_q == '0) && pend_q[2]) begin
      dir_d  = {1'b0, pend_q[1:0]};
      lock_d = LOCK_LOAD;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
      lock_q     <= '0;
      pend_q     <= '0;
      dir_q      <= DIR_IDLE;
      game_rst_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      lock_q     <= lock_d;
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      game_rst_q <= game_rst_d;
    end
  end

  assign io.dir      = dir_q;
  assign io.game_rst = game_rst_q;
  assign io.busy     = (lock_q != '0);
endmodule

// File: tb/tb_move_input.sv
// Bench for move_input: directed scenarios plus random button traffic, each
// cycle checked against a time-indexed behavioural model of the input stage.
module tb_move_input;
  localparam int D  = 4;
  localparam int L  = 48;
  localparam int NH = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  move_input_if bus();

  move_input #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk (clk),
    .rst (rst_n),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: s2 and deb histories indexed by edge number since reset release.
  int  n;
  bit  s1m [5];
  bit  s2h [5][NH];
  bit  debh [5][NH];
  int  lf [5];
  bit  has_issue;
  int  last_issue;
  logic [2:0] pend;
  logic [2:0] exp_dir;
  logic       exp_grst;
  logic       exp_busy;
  logic [1:0] exp_q [$];
  logic [1:0] got_q [$];

  task automatic model_reset();
    n = 0;
    has_issue = 1'b0;
    last_issue = 0;
    pend = 3'd0;
    for (int b = 0; b < 5; b++) begin
      s1m[b] = 1'b0;
      s2h[b][0] = 1'b0;
      debh[b][0] = 1'b0;
      lf[b] = 0;
    end
    exp_dir = 3'd4;
    exp_grst = 1'b0;
    exp_busy = 1'b0;
  endtask

  task automatic model_issue(input logic [1:0] code);
    exp_dir = {1'b0, code};
    has_issue = 1'b1;
    last_issue = n;
    pend = 3'd0;
    exp_q.push_back(code);
  endtask

  task automatic model_step(input logic [4:0] raw);
    logic [4:0] ev;
    bit flip;
    bit free;
    int win;
    n++;
    for (int b = 0; b < 5; b++) begin
      s2h[b][n] = s1m[b];
      s1m[b] = raw[b];
      // deb flips once s2 has held the opposite level for D samples since the last flip
      flip = (n - D >= lf[b]);
      if (flip)
        for (int j = n - D; j < n; j++)
          if (s2h[b][j] == debh[b][n-1]) flip = 1'b0;
      debh[b][n] = flip ? ~debh[b][n-1] : debh[b][n-1];
      if (flip) lf[b] = n;
      ev[b] = debh[b][n-1] & ~((n >= 2) ? debh[b][n-2] : 1'b0);
    end
    exp_dir = 3'd4;
    exp_grst = 1'b0;
    free = !(has_issue && (n - 1 - last_issue) < L);
    win = -1;
    for (int c = 3; c >= 0; c--) if (ev[c]) win = c;
    if (ev[4]) begin
      exp_grst = 1'b1;
      has_issue = 1'b0;
      pend = 3'd0;
    end else if (win >= 0) begin
      if (free) model_issue(2'(win));
      else pend = {1'b1, 2'(win)};
    end else if (free && pend[2]) begin
      model_issue(pend[1:0]);
    end
    exp_busy = has_issue && (n - last_issue) < L;
  endtask

  // Drivers: called at a falling edge, return at the next falling edge.
  task automatic step(input logic [4:0] raw);
    {bus.btn_reset, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = raw;
    @(posedge clk);
    model_step(raw);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    {bus.btn_reset, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 5'd0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (bus.dir !== 3'd4) begin
      n_err++; $display("FAIL reset_dir: got %0d, want 4", bus.dir);
    end
    n_cmp++;
    if (bus.game_rst !== 1'b0) begin
      n_err++; $display("FAIL reset_game_rst: got %b, want 0", bus.game_rst);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b, want 0", bus.busy);
    end
  endtask

  task automatic test_single_press();
    int ones = 0;
    int at = -1;
    int busy_cnt = 0;
    apply_reset();
    for (int c = 0; c < 80; c++) begin
      step((c < 20) ? 5'b00100 : 5'b00000);
      n_cmp++;
      if (bus.dir !== exp_dir || bus.game_rst !== exp_grst || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL single_press step %0d: dir=%0d game_rst=%b busy=%b, want dir=%0d game_rst=%b busy=%b",
                 c, bus.dir, bus.game_rst, bus.busy, exp_dir, exp_grst, exp_busy);
      end
      if (bus.dir === 3'd2) begin ones++; at = c; end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (ones != 1 || at != 6) begin
      n_err++; $display("FAIL single_press_latency: left seen %0d times, last at step %0d, want once at step 6", ones, at);
    end
    n_cmp++;
    if (busy_cnt != L) begin
      n_err++; $display("FAIL single_press_busy_len: got %0d cycles, want %0d", busy_cnt, L);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat = 8'b00110011;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step((c < 8) ? {4'b0000, pat[c]} : 5'b00000);
      n_cmp++;
      if (bus.dir !== 3'd4 || bus.busy !== 1'b0 || bus.dir !== exp_dir || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL bounce step %0d: dir=%0d busy=%b, want dir=4 busy=0", c, bus.dir, bus.busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    int downs = 0;
    int rights = 0;
    apply_reset();
    for (int c = 0; c < 90; c++) begin
      step((c < 10) ? 5'b01010 : 5'b00000);
      n_cmp++;
      if (bus.dir !== exp_dir || bus.game_rst !== exp_grst || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL simultaneous step %0d: dir=%0d game_rst=%b busy=%b, want dir=%0d game_rst=%b busy=%b",
                 c, bus.dir, bus.game_rst, bus.busy, exp_dir, exp_grst, exp_busy);
      end
      if (bus.dir === 3'd1) downs++;
      if (bus.dir === 3'd3) rights++;
    end
    n_cmp++;
    if (downs != 1 || rights != 0) begin
      n_err++; $display("FAIL simultaneous_count: down=%0d right=%0d, want down=1 right=0", downs, rights);
    end
  endtask

  task automatic test_pending();
    logic [4:0] raw;
    int cnt = 0;
    int first = -1;
    int second = -1;
    int second_at = -1;
    apply_reset();
    for (int c = 0; c < 130; c++) begin
      raw = 5'd0;
      if (c < 8) raw[0] = 1'b1;
      if (c >= 10 && c < 18) raw[2] = 1'b1;
      if (c >= 20 && c < 28) raw[3] = 1'b1;
      step(raw);
      n_cmp++;
      if (bus.dir !== exp_dir || bus.game_rst !== exp_grst || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL pending step %0d: dir=%0d game_rst=%b busy=%b, want dir=%0d game_rst=%b busy=%b",
                 c, bus.dir, bus.game_rst, bus.busy, exp_dir, exp_grst, exp_busy);
      end
      if (bus.dir !== 3'd4) begin
        cnt++;
        if (cnt == 1) first = int'(bus.dir);
        if (cnt == 2) begin second = int'(bus.dir); second_at = c; end
      end
    end
    n_cmp++;
    if (cnt != 2 || first != 0 || second != 3 || second_at != 6 + L + 1) begin
      n_err++;
      $display("FAIL pending_overwrite: %0d moves, first=%0d second=%0d at step %0d, want up then right at step %0d",
               cnt, first, second, second_at, 6 + L + 1);
    end
  endtask

  task automatic test_reset_btn();
    logic [4:0] raw;
    int moves = 0;
    int grst_cnt = 0;
    int grst_at = -1;
    logic busy_at_grst = 1'bx;
    apply_reset();
    for (int c = 0; c < 120; c++) begin
      raw = 5'd0;
      if (c < 8) raw[1] = 1'b1;
      if (c >= 10 && c < 18) raw[3] = 1'b1;
      if (c >= 20 && c < 28) raw[4] = 1'b1;
      step(raw);
      n_cmp++;
      if (bus.dir !== exp_dir || bus.game_rst !== exp_grst || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL reset_btn step %0d: dir=%0d game_rst=%b busy=%b, want dir=%0d game_rst=%b busy=%b",
                 c, bus.dir, bus.game_rst, bus.busy, exp_dir, exp_grst, exp_busy);
      end
      if (bus.dir !== 3'd4) moves++;
      if (bus.game_rst === 1'b1) begin grst_cnt++; grst_at = c; busy_at_grst = bus.busy; end
    end
    n_cmp++;
    if (grst_cnt != 1 || grst_at != 26 || busy_at_grst !== 1'b0) begin
      n_err++;
      $display("FAIL reset_btn_pulse: %0d pulses, last at step %0d busy=%b, want one at step 26 with busy=0",
               grst_cnt, grst_at, busy_at_grst);
    end
    n_cmp++;
    if (moves != 1) begin
      n_err++; $display("FAIL reset_btn_moves: got %0d moves, want 1", moves);
    end
  endtask

  task automatic test_async();
    logic was_busy;
    apply_reset();
    for (int c = 0; c < 8; c++) step((c < 8) ? 5'b00001 : 5'b00000);
    was_busy = bus.busy;
    #2;
    rst_n = 1'b0;
    {bus.btn_reset, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 5'd0;
    #1;
    n_cmp++;
    if (was_busy !== 1'b1 || bus.dir !== 3'd4 || bus.busy !== 1'b0 || bus.game_rst !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: busy_before=%b dir=%0d busy=%b game_rst=%b, want 1 / 4 0 0",
               was_busy, bus.dir, bus.busy, bus.game_rst);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step(5'd0);
      n_cmp++;
      if (bus.dir !== 3'd4 || bus.busy !== 1'b0 || bus.game_rst !== 1'b0 ||
          bus.dir !== exp_dir || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL async_quiet step %0d: dir=%0d busy=%b game_rst=%b, want 4 0 0",
                 c, bus.dir, bus.busy, bus.game_rst);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] raw = 5'd0;
    int hold = 0;
    bit q_ok;
    apply_reset();
    exp_q.delete();
    got_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 14);
        raw[3:0] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        raw[4] = ($urandom_range(0, 15) == 0);
      end
      hold--;
      step(raw);
      n_cmp++;
      if (bus.dir !== exp_dir || bus.game_rst !== exp_grst || bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL random step %0d: dir=%0d game_rst=%b busy=%b, want dir=%0d game_rst=%b busy=%b",
                 c, bus.dir, bus.game_rst, bus.busy, exp_dir, exp_grst, exp_busy);
      end
      if (bus.dir !== 3'd4) got_q.push_back(bus.dir[1:0]);
    end
    q_ok = (got_q.size() == exp_q.size()) && (exp_q.size() > 0);
    if (q_ok)
      for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) q_ok = 1'b0;
    n_cmp++;
    if (!q_ok) begin
      n_err++;
      $display("FAIL random_sequence: got %0d moves, want %0d matching moves", got_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_pending();
    test_reset_btn();
    test_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
